cci_mpf_drain_ctrl: RTL and testbench

CCI_MPF_DRAIN_CTRL -- requirements
Module: cci_mpf_drain_ctrl

---
 rtl/cci_mpf_drain_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_cci_mpf_drain_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cci_mpf_drain_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cci_mpf_drain_ctrl
// Brief    : Quiesces AFU traffic into MPF: blocks new requests, waits for the
//            TX streams to settle and MPF to empty, optionally fences c1, then
//            acknowledges. Optional fence stage enabled by MPF_DRAIN_FENCE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module cci_mpf_drain_ctrl #(
    parameter int SETTLE_CYCLES  = 8,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic clk,
    input  logic reset,
    input  logic drain_req,
    input  logic c0_tx_valid,
    input  logic c1_tx_valid,
    input  logic c0_not_empty,
    input  logic c1_not_empty,
    input  logic fence_grant,
    input  logic fence_rsp,
    output logic block_reqs,
    output logic fence_req,
    output logic drain_busy,
    output logic drain_ack,
    output logic timeout_err
);

    localparam int c_SETTLE_W = $clog2(SETTLE_CYCLES) + 1;
    localparam int c_TMO_W    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [c_SETTLE_W-1:0] c_SETTLE_LOAD = c_SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [c_SETTLE_W-1:0] c_SETTLE_ONE  = c_SETTLE_W'(1);
    localparam logic [c_TMO_W-1:0]    c_TMO_LAST    = c_TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [c_TMO_W-1:0]    c_TMO_ONE     = c_TMO_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_SETTLE     = 3'd1,
        ST_WAIT_EMPTY = 3'd2,
        ST_FENCE_REQ  = 3'd3,
        ST_FENCE_WAIT = 3'd4,
        ST_DONE       = 3'd5
    } state_t;

    state_t                r_state;
    logic [c_SETTLE_W-1:0] r_settle_cnt;
    logic [c_TMO_W-1:0]    r_tmo_cnt;
    logic                  r_active;
    logic                  r_ack;
    logic                  r_tmo_err;

    logic w_tx_any;
    logic w_exit;
    logic w_in_wait;
    logic w_tmo_hit;

    assign w_tx_any  = c0_tx_valid | c1_tx_valid;
    assign w_tmo_hit = (r_tmo_cnt == c_TMO_LAST);

`ifdef MPF_DRAIN_FENCE_EN
    logic r_fence_req;
    assign fence_req = r_fence_req;
`else
    logic w_unused_fence;
    assign w_unused_fence = fence_grant ^ fence_rsp;
    assign fence_req      = 1'b0;
`endif

    // Exit condition of whichever timed wait state is active; it beats timeout.
    always_comb begin
        w_exit    = 1'b0;
        w_in_wait = 1'b0;
        case (r_state)
            ST_WAIT_EMPTY: begin
                w_in_wait = 1'b1;
                w_exit    = !c0_not_empty && !c1_not_empty;
            end
`ifdef MPF_DRAIN_FENCE_EN
            ST_FENCE_REQ: begin
                w_in_wait = 1'b1;
                w_exit    = r_fence_req && fence_grant;
            end
            ST_FENCE_WAIT: begin
                w_in_wait = 1'b1;
                w_exit    = fence_rsp;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_settle_cnt <= '0;
            r_tmo_cnt    <= '0;
            r_active     <= 1'b0;
            r_ack        <= 1'b0;
            r_tmo_err    <= 1'b0;
`ifdef MPF_DRAIN_FENCE_EN
            r_fence_req  <= 1'b0;
`endif
        end else begin
            r_ack <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (drain_req) begin
                        r_state      <= ST_SETTLE;
                        r_settle_cnt <= c_SETTLE_LOAD;
                        r_tmo_err    <= 1'b0;
                        r_active     <= 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (w_tx_any) begin
                        r_settle_cnt <= c_SETTLE_LOAD;
                    end else if (r_settle_cnt == '0) begin
                        r_state   <= ST_WAIT_EMPTY;
                        r_tmo_cnt <= '0;
                    end else begin
                        r_settle_cnt <= r_settle_cnt - c_SETTLE_ONE;
                    end
                end
                ST_WAIT_EMPTY: begin
                    if (w_exit) begin
`ifdef MPF_DRAIN_FENCE_EN
                        r_state     <= ST_FENCE_REQ;
                        r_fence_req <= 1'b1;
                        r_tmo_cnt   <= '0;
`else
                        r_state <= ST_DONE;
                        r_ack   <= 1'b1;
`endif
                    end
                end
`ifdef MPF_DRAIN_FENCE_EN
                ST_FENCE_REQ: begin
                    if (w_exit) begin
                        r_state     <= ST_FENCE_WAIT;
                        r_fence_req <= 1'b0;
                        r_tmo_cnt   <= '0;
                    end
                end
                ST_FENCE_WAIT: begin
                    if (w_exit) begin
                        r_state <= ST_DONE;
                        r_ack   <= 1'b1;
                    end
                end
`endif
                ST_DONE: begin
                    if (!drain_req) begin
                        r_state  <= ST_IDLE;
                        r_active <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_active <= 1'b0;
                end
            endcase

            // Timeout is only checked once the counter is full, so it never wraps.
            if (w_in_wait && !w_exit) begin
                if (w_tmo_hit) begin
                    r_state   <= ST_IDLE;
                    r_active  <= 1'b0;
                    r_tmo_err <= 1'b1;
`ifdef MPF_DRAIN_FENCE_EN
                    r_fence_req <= 1'b0;
`endif
                end else begin
                    r_tmo_cnt <= r_tmo_cnt + c_TMO_ONE;
                end
            end
        end
    end

    assign block_reqs  = r_active;
    assign drain_busy  = r_active;
    assign drain_ack   = r_ack;
    assign timeout_err = r_tmo_err;

endmodule
`default_nettype wire

// File: tb/tb_cci_mpf_drain_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cci_mpf_drain_ctrl
// Brief    : Self-checking bench for cci_mpf_drain_ctrl using an event-time
//            reference model over per-cycle stimulus tables.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cci_mpf_drain_ctrl;

    localparam int S    = 8;
    localparam int T    = 64;
    localparam int MAXC = 256;
`ifdef MPF_DRAIN_FENCE_EN
    localparam int FENCE_LAT = 2;
`else
    localparam int FENCE_LAT = 0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic drain_req, c0_tx_valid, c1_tx_valid, c0_not_empty, c1_not_empty;
    logic fence_grant, fence_rsp;
    logic block_reqs, fence_req, drain_busy, drain_ack, timeout_err;

    bit dreq [MAXC];
    bit c0tx [MAXC];
    bit c1tx [MAXC];
    bit c0ne [MAXC];
    bit c1ne [MAXC];

    int n_checks = 0;
    int n_fails  = 0;
    bit exp_err  = 1'b0;

    cci_mpf_drain_ctrl #(
        .SETTLE_CYCLES  (S),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .drain_req    (drain_req),
        .c0_tx_valid  (c0_tx_valid),
        .c1_tx_valid  (c1_tx_valid),
        .c0_not_empty (c0_not_empty),
        .c1_not_empty (c1_not_empty),
        .fence_grant  (fence_grant),
        .fence_rsp    (fence_rsp),
        .block_reqs   (block_reqs),
        .fence_req    (fence_req),
        .drain_busy   (drain_busy),
        .drain_ack    (drain_ack),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic clear_stim();
        for (int n = 0; n < MAXC; n++) begin
            dreq[n] = 1'b0;
            c0tx[n] = 1'b0;
            c1tx[n] = 1'b0;
            c0ne[n] = 1'b0;
            c1ne[n] = 1'b0;
        end
    endtask

    // Expected timeline: settle ends after S consecutive TX-idle cycles from
    // cycle 1, the empty wait lasts at most T cycles, ack follows emptiness.
    task automatic run_seq(input string name);
        int s, w, e, ack, fin, run;
        bit tmo;
        logic [4:0] got_v, exp_v;
        s = -1;
        run = 0;
        for (int n = 1; n < MAXC; n++) begin
            if (c0tx[n] || c1tx[n]) run = 0;
            else run++;
            if (run == S) begin
                s = n;
                break;
            end
        end
        w = s + 1;
        e = -1;
        for (int n = w; n < w + T && n < MAXC; n++) begin
            if (!c0ne[n] && !c1ne[n]) begin
                e = n;
                break;
            end
        end
        if (e >= 0) begin
            tmo = 1'b0;
            ack = e + 1 + FENCE_LAT;
            fin = ack;
            while (fin < MAXC - 1 && dreq[fin]) fin++;
        end else begin
            tmo = 1'b1;
            ack = -1;
            fin = w + T - 1;
        end
        fence_grant = 1'b1;
        fence_rsp   = 1'b1;
        for (int n = 0; n <= fin + 3; n++) begin
            exp_v = {(n >= 1 && n <= fin), (n >= 1 && n <= fin), (n == ack),
                     ((n == 0) ? exp_err : (tmo && n > fin)),
                     (FENCE_LAT != 0 && e >= 0 && n == e + 1)};
            got_v = {block_reqs, drain_busy, drain_ack, timeout_err, fence_req};
            n_checks++;
            if (got_v !== exp_v) begin
                n_fails++;
                $display("FAIL %s cycle %0d {block,busy,ack,err,fence}: got %b expected %b",
                         name, n, got_v, exp_v);
            end
            drain_req    = (n < MAXC) ? dreq[n] : 1'b0;
            c0_tx_valid  = (n < MAXC) ? c0tx[n] : 1'b0;
            c1_tx_valid  = (n < MAXC) ? c1tx[n] : 1'b0;
            c0_not_empty = (n < MAXC) ? c0ne[n] : 1'b0;
            c1_not_empty = (n < MAXC) ? c1ne[n] : 1'b0;
            @(posedge clk);
            #1;
        end
        exp_err      = tmo;
        drain_req    = 1'b0;
        c0_tx_valid  = 1'b0;
        c1_tx_valid  = 1'b0;
        c0_not_empty = 1'b0;
        c1_not_empty = 1'b0;
        fence_grant  = 1'b0;
        fence_rsp    = 1'b0;
    endtask

    task automatic test_reset();
        logic [4:0] got_v;
        repeat (2) @(posedge clk);
        #1;
        got_v = {block_reqs, drain_busy, drain_ack, timeout_err, fence_req};
        n_checks++;
        if (got_v !== 5'b0) begin
            n_fails++;
            $display("FAIL reset_held outputs: got %b expected 00000", got_v);
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        got_v = {block_reqs, drain_busy, drain_ack, timeout_err, fence_req};
        n_checks++;
        if (got_v !== 5'b0) begin
            n_fails++;
            $display("FAIL reset_release outputs: got %b expected 00000", got_v);
        end
    endtask

    task automatic test_basic();
        clear_stim();
        for (int n = 0; n <= 15; n++) dreq[n] = 1'b1;
        run_seq("basic_hold");
    endtask

    task automatic test_settle_restart();
        clear_stim();
        dreq[0] = 1'b1;
        c1tx[3] = 1'b1;
        c1tx[7] = 1'b1;
        run_seq("settle_restart");
    endtask

    task automatic test_timeout();
        clear_stim();
        dreq[0] = 1'b1;
        for (int n = 0; n < 100; n++) c0ne[n] = 1'b1;
        run_seq("timeout");
    endtask

    task automatic test_exit_tie();
        clear_stim();
        dreq[0] = 1'b1;
        for (int n = 0; n < S + 1 + T - 1; n++) c1ne[n] = 1'b1;
        run_seq("exit_tie_timeout");
        clear_stim();
        dreq[0] = 1'b1;
        for (int n = 0; n < S + 1 + T; n++) c1ne[n] = 1'b1;
        run_seq("exit_one_late");
    endtask

    task automatic test_random();
        int k, h;
        for (int it = 0; it < 16; it++) begin
            clear_stim();
            h = $urandom_range(0, 8);
            for (int n = 0; n <= h; n++) dreq[n] = 1'b1;
            for (int n = 0; n < 40; n++) begin
                c0tx[n] = ($urandom_range(0, 5) == 0);
                c1tx[n] = ($urandom_range(0, 5) == 0);
            end
            k = $urandom_range(0, 110);
            for (int n = 0; n < MAXC; n++) begin
                c0ne[n] = (n < k) ? 1'b1 : ($urandom_range(0, 3) == 0);
                c1ne[n] = (n < k) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 3) == 0);
            end
            run_seq("random");
        end
    endtask

`ifdef MPF_DRAIN_FENCE_EN
    task automatic test_fence();
        logic [4:0] got_v, exp_v;
        int issues, fr_high;
        issues  = 0;
        fr_high = 0;
        for (int n = 0; n <= 30; n++) begin
            exp_v = {(n >= 1 && n <= 26), (n >= 1 && n <= 26), (n == 26),
                     ((n == 0) ? exp_err : 1'b0), (n >= 10 && n <= 15)};
            got_v = {block_reqs, drain_busy, drain_ack, timeout_err, fence_req};
            n_checks++;
            if (got_v !== exp_v) begin
                n_fails++;
                $display("FAIL fence cycle %0d {block,busy,ack,err,fence}: got %b expected %b",
                         n, got_v, exp_v);
            end
            drain_req   = (n == 0);
            fence_grant = (n >= 15);
            fence_rsp   = (n == 25);
            if (fence_req) fr_high++;
            if (fence_req && fence_grant) issues++;
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (issues !== 1 || fr_high !== 6) begin
            n_fails++;
            $display("FAIL fence_issue: got issues=%0d req_cycles=%0d expected 1 and 6",
                     issues, fr_high);
        end
        fence_grant = 1'b0;
        fence_rsp   = 1'b0;
        exp_err     = 1'b0;
    endtask
`endif

    task automatic test_reset_mid();
        logic [4:0] got_v;
        drain_req   = 1'b1;
        fence_grant = 1'b1;
        fence_rsp   = 1'b0;
`ifdef MPF_DRAIN_FENCE_EN
        c0_not_empty = 1'b0;
`else
        c0_not_empty = 1'b1;
`endif
        @(posedge clk);
        #1;
        drain_req = 1'b0;
        repeat (13) @(posedge clk);
        #1;
        n_checks++;
        if ({block_reqs, drain_busy} !== 2'b11) begin
            n_fails++;
            $display("FAIL reset_mid_pre {block,busy}: got %b expected 11",
                     {block_reqs, drain_busy});
        end
        #2;
        reset = 1'b1;
        #1;
        got_v = {block_reqs, drain_busy, drain_ack, timeout_err, fence_req};
        n_checks++;
        if (got_v !== 5'b0) begin
            n_fails++;
            $display("FAIL reset_mid_async outputs: got %b expected 00000", got_v);
        end
        @(posedge clk);
        #1;
        reset        = 1'b0;
        fence_rsp    = 1'b1;
        c0_not_empty = 1'b0;
        for (int n = 0; n < 6; n++) begin
            @(posedge clk);
            #1;
            got_v = {block_reqs, drain_busy, drain_ack, timeout_err, fence_req};
            n_checks++;
            if (got_v !== 5'b0) begin
                n_fails++;
                $display("FAIL reset_mid_stale cycle %0d outputs: got %b expected 00000", n, got_v);
            end
        end
        fence_rsp   = 1'b0;
        fence_grant = 1'b0;
        exp_err     = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        drain_req    = 1'b0;
        c0_tx_valid  = 1'b0;
        c1_tx_valid  = 1'b0;
        c0_not_empty = 1'b0;
        c1_not_empty = 1'b0;
        fence_grant  = 1'b0;
        fence_rsp    = 1'b0;
        test_reset();
        test_basic();
        test_settle_restart();
        test_timeout();
        test_exit_tie();
        test_random();
`ifdef MPF_DRAIN_FENCE_EN
        test_fence();
`endif
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
